// File: rtl/ps2_byte_receiver.sv
// PS/2 device-to-host byte receiver: input synchronisers, optional glitch
// filter (define PS2_RX_GLITCH_FILTER_EN), frame FSM with inactivity timeout
// and a first-word-fall-through receive FIFO with sticky overflow.
`timescale 1ns/1ps
module ps2_byte_receiver #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FIFO_DEPTH     = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4
) (
   input  logic                         CLK,
   input  logic                         RESET_N,
   input  logic                         CLK_PS2_IN,
   input  logic                         DATA_PS2_IN,
   input  logic                         RX_ENABLE,
   input  logic                         BYTE_POP,
   output logic [7:0]                   BYTE_DATA,
   output logic [1:0]                   BYTE_ERR,
   output logic                         BYTE_VALID,
   output logic [$clog2(FIFO_DEPTH):0]  FIFO_LEVEL,
   output logic                         OVERFLOW,
   input  logic                         CLR_OVERFLOW,
   output logic                         FRAME_TIMEOUT
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;

   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic                   clk_s, data_s, clk_cond, data_cond, clk_prev, fall;
   state_t                 state, next_state;
   logic                   tmo_hit;
   logic [TW-1:0]          tmo_cnt;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift;
   logic                   par_err, push;
   logic [9:0]             push_word;
   logic [9:0]             mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [AW:0]            level;
   logic                   pop_ok, full, wr_ok, ovf_set;

   // Synchronisers; reset to the idle-bus level so no edge is seen on release
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], CLK_PS2_IN};
         data_sync <= {data_sync[SYNC_STAGES-2:0], DATA_PS2_IN};
      end
   end
   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

`ifdef PS2_RX_GLITCH_FILTER_EN
   localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
   logic [FW-1:0] clk_fcnt, data_fcnt;

   // Conditioned value follows the input only after FILTER_LEN differing samples
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         clk_cond  <= 1'b1;
         data_cond <= 1'b1;
         clk_fcnt  <= '0;
         data_fcnt <= '0;
      end else begin
         if (clk_s == clk_cond) clk_fcnt <= '0;
         else if (clk_fcnt == FW'(FILTER_LEN - 1)) begin
            clk_cond <= clk_s;
            clk_fcnt <= '0;
         end else clk_fcnt <= clk_fcnt + 1'b1;
         if (data_s == data_cond) data_fcnt <= '0;
         else if (data_fcnt == FW'(FILTER_LEN - 1)) begin
            data_cond <= data_s;
            data_fcnt <= '0;
         end else data_fcnt <= data_fcnt + 1'b1;
      end
   end
`else
   assign clk_cond  = clk_s;
   assign data_cond = data_s;
`endif

   // Previous conditioned PS/2 clock for falling-edge detection
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) clk_prev <= 1'b1;
      else          clk_prev <= clk_cond;
   end
   assign fall = clk_prev & ~clk_cond;

   // FSM state register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= next_state;
   end

   // Next state; a timeout from any active state wins and returns to IDLE
   always_comb begin
      next_state = state;
      tmo_hit    = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
      case (state)
         IDLE:      if (fall && !data_cond && RX_ENABLE) next_state = DATA;
         DATA:      if (fall && bit_cnt == 3'd7)         next_state = PARITY;
         PARITY:    if (fall)                            next_state = STOP;
         STOP:      if (fall)                            next_state = WAIT_IDLE;
         WAIT_IDLE: if (clk_cond && data_cond)           next_state = IDLE;
         default:                                        next_state = IDLE;
      endcase
      if (tmo_hit) next_state = IDLE;
   end

   // Frame datapath: timeout counter, bit counter, shifter, status, push request
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         tmo_cnt       <= '0;
         bit_cnt       <= '0;
         shift         <= '0;
         par_err       <= 1'b0;
         push          <= 1'b0;
         push_word     <= '0;
         FRAME_TIMEOUT <= 1'b0;
      end else begin
         FRAME_TIMEOUT <= tmo_hit;
         push          <= 1'b0;
         if (state == IDLE || fall || tmo_hit) tmo_cnt <= '0;
         else                                  tmo_cnt <= tmo_cnt + 1'b1;
         if (state == IDLE) bit_cnt <= '0;
         else if (state == DATA && fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= {data_cond, shift[7:1]};
         end
         if (state == PARITY && fall) par_err <= (data_cond != ~^shift);
         if (state == STOP && fall) begin
            push      <= 1'b1;
            push_word <= {~data_cond, par_err, shift};
         end
      end
   end

   assign pop_ok  = BYTE_POP && (level != '0);
   assign full    = (level == (AW+1)'(FIFO_DEPTH));
   assign wr_ok   = push && (!full || pop_ok);
   assign ovf_set = push && full && !pop_ok;

   // FIFO storage; contents are only visible through the gated head outputs
   always_ff @(posedge CLK) begin
      if (wr_ok) mem[wr_ptr] <= push_word;
   end

   // FIFO pointers, occupancy and sticky overflow (clear beats set)
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (CLR_OVERFLOW) OVERFLOW <= 1'b0;
         else if (ovf_set) OVERFLOW <= 1'b1;
      end
   end

   assign BYTE_VALID = (level != '0);
   assign FIFO_LEVEL = level;
   assign BYTE_DATA  = BYTE_VALID ? mem[rd_ptr][7:0] : 8'h00;
   assign BYTE_ERR   = BYTE_VALID ? mem[rd_ptr][9:8] : 2'b00;
endmodule

// File: doc/ps2_byte_receiver.md
PS2_BYTE_RECEIVER -- requirements
Module: ps2_byte_receiver

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 100000, meaning CLK cycles without a PS/2 clock falling edge before a frame aborts (1 ms at 100 MHz).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of 2, >=2).
REQ-003 SHALL provide parameter SYNC_STAGES, default 2, meaning synchroniser flops per PS/2 input (>=2).
REQ-004 SHALL provide parameter FILTER_LEN, default 4, meaning consecutive equal samples required by the glitch filter (>=2).
REQ-005 SHALL provide port CLK  in  1  system clock, all logic rising-edge.
REQ-006 SHALL provide port RESET_N  in  1  one clock; reset is asynchronous and active-low.
REQ-007 SHALL provide port CLK_PS2_IN  in  1  PS/2 clock line, asynchronous.
REQ-008 SHALL provide port DATA_PS2_IN  in  1  PS/2 data line, asynchronous.
REQ-009 SHALL provide port RX_ENABLE  in  1  permits frame starts.
REQ-010 SHALL provide port BYTE_POP  in  1  consumer removes FIFO head.
REQ-011 SHALL provide port BYTE_DATA  out  8  FIFO head data byte.
REQ-012 SHALL provide port BYTE_ERR  out  2  FIFO head status: [0] parity error, [1] stop error.
REQ-013 SHALL provide port BYTE_VALID  out  1  FIFO non-empty.
REQ-014 SHALL provide port FIFO_LEVEL  out  log2(FIFO_DEPTH)+1  occupied entries.
REQ-015 SHALL provide port OVERFLOW  out  1  sticky: byte dropped because FIFO full.
REQ-016 SHALL provide port CLR_OVERFLOW  in  1  clears OVERFLOW.
REQ-017 SHALL provide port FRAME_TIMEOUT  out  1  one-cycle pulse on frame abort.

Function
REQ-018 Both PS/2 inputs SHALL pass through SYNC_STAGES flops; falling edge = previous conditioned clock 1, current 0.
REQ-019 FSM states SHALL be IDLE, DATA, PARITY, STOP, WAIT_IDLE; unused encodings go to IDLE.
REQ-020 IDLE->DATA on falling edge with data 0 and RX_ENABLE 1; bit counter and timeout counter cleared.
REQ-021 DATA: each falling edge shifts data in LSB-first; after 8th bit -> PARITY.
REQ-022 PARITY: on falling edge, parity error = (data != odd-parity bit of shifted byte); -> STOP.
REQ-023 STOP: on falling edge, stop error = (data == 0); byte+2-bit status pushed on next CLK edge; -> WAIT_IDLE.
REQ-024 WAIT_IDLE -> IDLE when conditioned clock and data are both 1.
REQ-025 Timeout counter SHALL clear on every falling edge and in IDLE; in any other state reaching TIMEOUT_CYCLES-1 -> IDLE, FRAME_TIMEOUT pulses one cycle, partial byte discarded, nothing pushed.
REQ-026 RX_ENABLE deassertion mid-frame SHALL NOT abort the frame; it only gates starts.
REQ-027 FIFO SHALL be first-word-fall-through; BYTE_VALID high from the cycle after the push into an empty FIFO.
REQ-028 BYTE_POP with BYTE_VALID 0 SHALL be ignored.
REQ-029 Push when full without simultaneous pop: byte dropped, OVERFLOW set, contents unchanged.
REQ-030 Push and pop same cycle SHALL both occur, level unchanged, no overflow, including when full.
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH; FIFO_LEVEL never exceeds FIFO_DEPTH.
REQ-032 CLR_OVERFLOW SHALL take priority over a same-cycle overflow set (OVERFLOW = 0 next cycle).

Reset
REQ-033 RESET_N low SHALL asynchronously force: FSM IDLE, counters 0, FIFO empty, BYTE_DATA 8'h00, BYTE_ERR 2'b00, BYTE_VALID 0, FIFO_LEVEL 0, OVERFLOW 0, FRAME_TIMEOUT 0, synchroniser/filter outputs 1 (idle bus).
REQ-034 Reset mid-frame SHALL discard the partial frame; after release, reception resumes only at the next valid start bit.

Configuration
REQ-035 Macro PS2_RX_GLITCH_FILTER_EN defined: each synchronised input SHALL change its conditioned value only after FILTER_LEN consecutive equal samples (adds FILTER_LEN cycles latency).
REQ-036 Macro undefined: synchronised inputs SHALL be used directly; FILTER_LEN unused; all other behaviour identical.

Verification
REQ-037 Frame 0x5A, parity 1, stop 1 -> BYTE_DATA 0x5A, BYTE_ERR 00, BYTE_VALID 1, FIFO_LEVEL 1.
REQ-038 Frame 0x5A, parity 0, stop 0 -> BYTE_ERR 11; pop -> BYTE_VALID 0, FIFO_LEVEL 0.
REQ-039 FIFO_DEPTH 4, five frames 0x01..0x05 no pops -> level 4, OVERFLOW 1, pops return 0x01..0x04.
REQ-040 TIMEOUT_CYCLES 1000, stop PS/2 clock after 3 data bits -> FRAME_TIMEOUT one pulse at 1000 cycles, level unchanged, next good frame 0xA5 received correctly.
REQ-041 Full FIFO, stop edge coincident with BYTE_POP -> level stays 4, OVERFLOW 0, new byte at tail.
REQ-042 With PS2_RX_GLITCH_FILTER_EN, FILTER_LEN 4, 2-cycle low glitch on CLK_PS2_IN in IDLE -> no frame start; without macro -> frame starts.
